pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage RV32I pipeline. It detects load-use hazards, sequences branch redirects and IF/ID flushes, and freezes the whole pipeline while a data-memory access waits. It drives the IF stage stall and branch-enable inputs plus the per-stage flush, bubble and freeze controls. A wait-timeout watchdog traps a hung memory port.

Parameters:
FLUSH_CYCLES, 1, number of cycles IF_ID_flush_o is held after a taken branch (1..15)
WAIT_TIMEOUT, 255, max consecutive dmem wait cycles before FAULT (1..65535)
REG_ADDR_W, 5, register index width

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
ID_rs1_i  in  REG_ADDR_W  rs1 index of instruction in ID
ID_rs2_i  in  REG_ADDR_W  rs2 index of instruction in ID
ID_rs1_used_i  in  1  ID instruction reads rs1
ID_rs2_used_i  in  1  ID instruction reads rs2
ID_branch_en_i  in  1  branch/jump resolved taken in ID
EX_rd_i  in  REG_ADDR_W  destination of instruction in EX
EX_memread_i  in  1  EX instruction is a load
MEM_req_i  in  1  MEM stage has a valid dmem access this cycle
dmem_ready_i  in  1  dmem completes the access this cycle
IF_stall_o  out  1  hold PC and re-present the current fetch
IF_branch_en_o  out  1  redirect PC to branch target
IF_ID_flush_o  out  1  squash IF/ID register
ID_EX_bubble_o  out  1  insert NOP into ID/EX
pipe_freeze_o  out  1  hold all pipeline registers
timeout_o  out  1  sticky watchdog fault flag
state_o  out  2  current FSM state (debug)

Behaviour:
- Reset: async on rst_ni=0. State=RUN, flush_cnt=0, wait_cnt=0, timeout_o=0. While rst_ni=0: IF_stall_o=1, IF_ID_flush_o=1, all other outputs 0.
- Load-use: lu = EX_memread_i & (EX_rd_i!=0) & ((ID_rs1_used_i & ID_rs1_i==EX_rd_i) | (ID_rs2_used_i & ID_rs2_i==EX_rd_i)). Combinational, 0-cycle latency.
- mw = MEM_req_i & ~dmem_ready_i.
- Outputs are combinational from state and inputs. Registered state only.
- States: RUN=0, FLUSH=1, MEM_WAIT=2, FAULT=3.
- RUN, priority mw > lu > branch:
  - mw: pipe_freeze_o=1, IF_stall_o=1; next MEM_WAIT, wait_cnt<=1.
  - lu: IF_stall_o=1, ID_EX_bubble_o=1; ID_branch_en_i ignored; stay RUN.
  - branch: IF_branch_en_o=1, IF_ID_flush_o=1. If FLUSH_CYCLES>1, next FLUSH with flush_cnt<=FLUSH_CYCLES-1; else stay RUN.
- FLUSH:
  - IF_ID_flush_o=1 and ID_branch_en_i ignored.
  - If mw: pipe_freeze_o=1, IF_stall_o=1, and flush_cnt holds.
  - Else flush_cnt decrements; at flush_cnt==1 next RUN.
- MEM_WAIT:
  - pipe_freeze_o=IF_stall_o=~dmem_ready_i.
  - On dmem_ready_i=1: pipeline advances that cycle; next RUN; wait_cnt<=0.
  - Else wait_cnt++; at wait_cnt==WAIT_TIMEOUT next FAULT.
  - lu and branch not evaluated.
- FAULT: pipe_freeze_o=1, IF_stall_o=1, timeout_o=1. Exit only by reset.
- Simultaneous events: stall and branch in the same cycle means stall wins and the branch is re-presented by the held ID stage. Freeze dominates bubble and flush: bubble and flush are 0 when pipe_freeze_o=1, except the reset case.
- wait_cnt is 16 bits and saturates; no wrap.

Optional Feature:
Macro HAZARD_PERF_CNT_EN.
- Defined: adds outputs stall_cnt_o[31:0] and flush_cnt_o[31:0].
  - stall_cnt_o increments each cycle IF_stall_o=1 with rst_ni=1.
  - flush_cnt_o increments each cycle IF_ID_flush_o=1 with rst_ni=1.
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset: rst_ni=0 mid-MEM_WAIT -> same cycle: state_o=0, IF_stall_o=1, IF_ID_flush_o=1, pipe_freeze_o=0; after release with no hazards, all outputs 0.
- Load-use: EX_memread_i=1, EX_rd_i=5, ID_rs2_i=5, ID_rs2_used_i=1 -> IF_stall_o=1, ID_EX_bubble_o=1 for exactly 1 cycle. With EX_rd_i=0 -> no stall.
- Branch, FLUSH_CYCLES=3: ID_branch_en_i pulse -> IF_branch_en_o=1 for 1 cycle; IF_ID_flush_o=1 for 3 cycles; state_o sequence 0,1,1,0.
- Mem wait: MEM_req_i=1, dmem_ready_i=0 for 4 cycles then 1 -> pipe_freeze_o=1 for 4 cycles, then 0 on the ready cycle; state_o=2 then 0.
- Priority: lu=1 and ID_branch_en_i=1 together -> IF_branch_en_o=0, bubble=1. Branch re-presented the next cycle -> IF_branch_en_o=1.
- Timeout, WAIT_TIMEOUT=8: dmem_ready_i held 0 -> state_o=3 after 8 wait cycles; timeout_o=1 sticky, ignoring dmem_ready_i=1, until rst_ni=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipeline: load-use stalls, branch flushes,
// dmem-wait freeze and a wait watchdog. Optional perf counters behind HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned WAIT_TIMEOUT = 255,
    parameter int unsigned REG_ADDR_W   = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [REG_ADDR_W-1:0] ID_rs1_i,
    input  logic [REG_ADDR_W-1:0] ID_rs2_i,
    input  logic                  ID_rs1_used_i,
    input  logic                  ID_rs2_used_i,
    input  logic                  ID_branch_en_i,
    input  logic [REG_ADDR_W-1:0] EX_rd_i,
    input  logic                  EX_memread_i,
    input  logic                  MEM_req_i,
    input  logic                  dmem_ready_i,
    output logic                  IF_stall_o,
    output logic                  IF_branch_en_o,
    output logic                  IF_ID_flush_o,
    output logic                  ID_EX_bubble_o,
    output logic                  pipe_freeze_o,
    output logic                  timeout_o,
    output logic [1:0]            state_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cnt_o,
    output logic [31:0]           flush_cnt_o
`endif
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_FAULT    = 2'd3
    } state_e;

    localparam logic [3:0]  FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
    localparam logic [15:0] WAIT_LIMIT = 16'(WAIT_TIMEOUT);

    state_e      state_q, state_d;
    logic [3:0]  flush_cnt_q, flush_cnt_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic [15:0] wait_inc;
    logic        lu, mw;

    // dmem handshake: an access completes in a cycle with MEM_req_i & dmem_ready_i;
    // MEM_req_i & ~dmem_ready_i means the access is still waiting and the pipe must hold.
    assign mw = MEM_req_i & ~dmem_ready_i;
    assign lu = EX_memread_i & (EX_rd_i != '0) &
                ((ID_rs1_used_i & (ID_rs1_i == EX_rd_i)) |
                 (ID_rs2_used_i & (ID_rs2_i == EX_rd_i)));

    assign wait_inc = (wait_cnt_q == 16'hFFFF) ? wait_cnt_q : wait_cnt_q + 16'd1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        flush_cnt_d    = flush_cnt_q;
        wait_cnt_d     = wait_cnt_q;
        IF_stall_o     = 1'b0;
        IF_branch_en_o = 1'b0;
        IF_ID_flush_o  = 1'b0;
        ID_EX_bubble_o = 1'b0;
        pipe_freeze_o  = 1'b0;
        timeout_o      = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (mw) begin
                    pipe_freeze_o = 1'b1;
                    IF_stall_o    = 1'b1;
                    state_d       = ST_MEM_WAIT;
                    wait_cnt_d    = 16'd1;
                end else if (lu) begin
                    // a branch seen alongside the stall is re-presented by the held ID stage
                    IF_stall_o     = 1'b1;
                    ID_EX_bubble_o = 1'b1;
                end else if (ID_branch_en_i) begin
                    IF_branch_en_o = 1'b1;
                    IF_ID_flush_o  = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = FLUSH_INIT;
                    end
                end
            end
            ST_FLUSH: begin
                if (mw) begin
                    pipe_freeze_o = 1'b1;
                    IF_stall_o    = 1'b1;
                end else begin
                    IF_ID_flush_o = 1'b1;
                    flush_cnt_d   = flush_cnt_q - 4'd1;
                    if (flush_cnt_q <= 4'd1) begin
                        state_d     = ST_RUN;
                        flush_cnt_d = '0;
                    end
                end
            end
            ST_MEM_WAIT: begin
                pipe_freeze_o = ~dmem_ready_i;
                IF_stall_o    = ~dmem_ready_i;
                if (dmem_ready_i) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_inc;
                    if (wait_inc >= WAIT_LIMIT) state_d = ST_FAULT;
                end
            end
            ST_FAULT: begin
                pipe_freeze_o = 1'b1;
                IF_stall_o    = 1'b1;
                timeout_o     = 1'b1;
            end
            default: state_d = ST_RUN;
        endcase
        // while in reset, fetch is held and IF/ID squashed regardless of state
        if (!rst_ni) begin
            IF_stall_o     = 1'b1;
            IF_ID_flush_o  = 1'b1;
            IF_branch_en_o = 1'b0;
            ID_EX_bubble_o = 1'b0;
            pipe_freeze_o  = 1'b0;
            timeout_o      = 1'b0;
        end
    end

    assign state_o = state_q;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (IF_stall_o)    stall_cnt_o <= stall_cnt_o + 32'd1;
            if (IF_ID_flush_o) flush_cnt_o <= flush_cnt_o + 32'd1;
        end
    end
`endif

endmodule
